// File: rtl/invader_pkg.sv
// Shared constants and types for the invader sprite draw stage.
//   SPRITE_W/SPRITE_H : sprite box size in pixels (one animation frame of the ROM)
//   TRANSPARENT_KEY   : ROM colour treated as see-through when transparency is built in
//   HCNT_W/VCNT_W     : raster counter widths
//   RGB_W             : packed {r,g,b} pixel width
//   vga_timing_t      : the timing bundle carried alongside each pixel
package invader_pkg;

  localparam int unsigned SPRITE_W = 64;
  localparam int unsigned SPRITE_H = 32;
  localparam int unsigned HCNT_W   = 11;
  localparam int unsigned VCNT_W   = 11;
  localparam int unsigned RGB_W    = 12;

  localparam logic [RGB_W-1:0] TRANSPARENT_KEY = 12'h000;

  typedef struct packed {
    logic [VCNT_W-1:0] vcount;
    logic [HCNT_W-1:0] hcount;
    logic              vsync;
    logic              hsync;
    logic              vblnk;
    logic              hblnk;
  } vga_timing_t;

endpackage

// File: rtl/signal_delay.sv
// Generic register chain: data_o is data_i delayed by CLK_DEL clock cycles.
// All stages clear asynchronously while rst_n is low.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   data_i : WIDTH-bit input
//   data_o : WIDTH-bit output, CLK_DEL cycles late (CLK_DEL >= 1)
module signal_delay #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [CLK_DEL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CLK_DEL); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < int'(CLK_DEL); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_o = stage_q[CLK_DEL-1];

endmodule

// File: rtl/invader_draw.sv
// Invader sprite overlay stage in the VGA pixel chain.
// Walks the raster, addresses a 64x64 sprite ROM (two 64x32 animation frames) for an invader
// anchored at (xpos, ypos), and mixes the ROM colour over the incoming pixel. Every output is
// the corresponding input delayed exactly two clocks.
//   clk, rst_n                          : pixel clock, asynchronous active-low reset
//   vcount_in/hcount_in/*sync_in/*blnk_in : incoming raster timing
//   rgb_in                              : background pixel
//   xpos/ypos/visible                   : sprite placement; sampled once per frame at vblank start
//   rom_addr / rom_rgb                  : {frame, row[4:0], col[5:0]} out, colour back 1 clk later
//   *_out                               : timing delayed 2, rgb_out the mixed pixel
// Build option: define INVADER_TRANSPARENT_EN to let TRANSPARENT_KEY ROM pixels show rgb_in.
module invader_draw
  import invader_pkg::*;
#(
  parameter int unsigned ANIM_PERIOD = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] vcount_in,
  input  logic [10:0] hcount_in,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        vblnk_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic        visible,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] vcount_out,
  output logic [10:0] hcount_out,
  output logic        vsync_out,
  output logic        hsync_out,
  output logic        vblnk_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out
);

  localparam int unsigned CntW = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ANIM_PERIOD - 1);

  // Per-frame shadow state, updated only at vblank start so a frame never tears.
  logic            vblnk_prev_q;
  logic [10:0]     x_q, x_d;
  logic [10:0]     y_q, y_d;
  logic            vis_q, vis_d;
  logic            frame_q, frame_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            vblnk_rise;

  assign vblnk_rise = vblnk_in & ~vblnk_prev_q;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    vis_d   = vis_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    if (vblnk_rise) begin
      x_d   = xpos;
      y_d   = ypos;
      vis_d = visible;
      if (cnt_q == CntMax) begin
        cnt_d   = '0;
        frame_d = ~frame_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      vis_q        <= 1'b0;
      cnt_q        <= '0;
      frame_q      <= 1'b0;
    end else begin
      vblnk_prev_q <= vblnk_in;
      x_q          <= x_d;
      y_q          <= y_d;
      vis_q        <= vis_d;
      cnt_q        <= cnt_d;
      frame_q      <= frame_d;
    end
  end

  // Box test in 12 bits so an anchor near 2047 pushes the box off-screen instead of wrapping.
  logic [11:0] h_ext, v_ext, x_ext, y_ext, x_end, y_end;
  logic        in_box;
  logic [5:0]  dx;
  logic [4:0]  dy;

  assign h_ext = {1'b0, hcount_in};
  assign v_ext = {1'b0, vcount_in};
  assign x_ext = {1'b0, x_q};
  assign y_ext = {1'b0, y_q};
  assign x_end = x_ext + 12'(SPRITE_W);
  assign y_end = y_ext + 12'(SPRITE_H);

  assign in_box = vis_q & (h_ext >= x_ext) & (h_ext < x_end) &
                  (v_ext >= y_ext) & (v_ext < y_end);

  assign dx = 6'(hcount_in - x_q);
  assign dy = 5'(vcount_in - y_q);

  assign rom_addr = in_box ? {frame_q, dy, dx} : 12'h000;

  // Stage 1: timing, box flag and background pixel line up with the ROM read latency.
  vga_timing_t timing_in, timing1, timing2;
  logic        in_box1;
  logic [11:0] rgb1;

  assign timing_in = '{vcount: vcount_in, hcount: hcount_in, vsync: vsync_in,
                       hsync: hsync_in, vblnk: vblnk_in, hblnk: hblnk_in};

  signal_delay #(
    .WIDTH  ($bits(vga_timing_t) + 1 + RGB_W),
    .CLK_DEL(1)
  ) u_stage1 (
    .clk   (clk),
    .rst_n (rst_n),
    .data_i({timing_in, in_box, rgb_in}),
    .data_o({timing1, in_box1, rgb1})
  );

  // Stage 2: timing delayed once more, pixel mixed with the now-valid ROM data.
  signal_delay #(
    .WIDTH  ($bits(vga_timing_t)),
    .CLK_DEL(1)
  ) u_stage2 (
    .clk   (clk),
    .rst_n (rst_n),
    .data_i(timing1),
    .data_o(timing2)
  );

  logic        blank1;
  logic        pixel_opaque;
  logic [11:0] rgb_d, rgb_q;

  assign blank1 = timing1.vblnk | timing1.hblnk;

`ifdef INVADER_TRANSPARENT_EN
  assign pixel_opaque = (rom_rgb != TRANSPARENT_KEY);
`else
  assign pixel_opaque = 1'b1;
`endif

  always_comb begin
    rgb_d = rgb1;
    if (blank1) begin
      rgb_d = 12'h000;
    end else if (in_box1 && pixel_opaque) begin
      rgb_d = rom_rgb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign vcount_out = timing2.vcount;
  assign hcount_out = timing2.hcount;
  assign vsync_out  = timing2.vsync;
  assign hsync_out  = timing2.hsync;
  assign vblnk_out  = timing2.vblnk;
  assign hblnk_out  = timing2.hblnk;
  assign rgb_out    = rgb_q;

endmodule

// File: tb/tb_invader_draw.sv
// Directed bench for invader_draw: reset, placement, tear-free latching, animation, edge
// clipping, blanking and transparency. ROM model returns ~addr one clock after the address.
module tb_invader_draw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] vcount_in, hcount_in, xpos, ypos;
  logic        vsync_in, hsync_in, vblnk_in, hblnk_in, visible;
  logic [11:0] rgb_in, rom_rgb, rom_addr, rgb_out;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
  logic        rom_zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  invader_draw #(
    .ANIM_PERIOD(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vcount_in (vcount_in),
    .hcount_in (hcount_in),
    .vsync_in  (vsync_in),
    .hsync_in  (hsync_in),
    .vblnk_in  (vblnk_in),
    .hblnk_in  (hblnk_in),
    .rgb_in    (rgb_in),
    .xpos      (xpos),
    .ypos      (ypos),
    .visible   (visible),
    .rom_addr  (rom_addr),
    .rom_rgb   (rom_rgb),
    .vcount_out(vcount_out),
    .hcount_out(hcount_out),
    .vsync_out (vsync_out),
    .hsync_out (hsync_out),
    .vblnk_out (vblnk_out),
    .hblnk_out (hblnk_out),
    .rgb_out   (rgb_out)
  );

  // Synchronous ROM model; rom_zero forces the key colour 000.
  initial rom_rgb = 12'h000;
  always @(posedge clk) rom_rgb <= rom_zero ? 12'h000 : ~rom_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic vb,
                       input logic hb, input logic [11:0] rgb);
    hcount_in = h;
    vcount_in = v;
    vblnk_in  = vb;
    hblnk_in  = hb;
    vsync_in  = vb;
    hsync_in  = hb;
    rgb_in    = rgb;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vrise();
    drive(11'd0, 11'd600, 1'b1, 1'b1, 12'h000);
    tick();
    drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h000);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    rom_zero = 1'b0;
    xpos = '0; ypos = '0; visible = 1'b0;
    drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h000);
    #11 rst_n = 1'b1;
    tick();

    // Mid-line traffic, then asynchronous reset between edges.
    drive(11'd300, 11'd10, 1'b0, 1'b1, 12'h321);
    tick();
    tick();
    chk("pre_reset_hcount", 32'(hcount_out), 32'd300);
    chk("pre_reset_sync_blank", 32'({vsync_out, hsync_out, vblnk_out, hblnk_out}), 32'b0101);
    #3 rst_n = 1'b0;
    #1;
    chk("reset_hcount", 32'(hcount_out), 32'd0);
    chk("reset_sync_blank", 32'({vsync_out, hsync_out, vblnk_out, hblnk_out}), 32'd0);
    chk("reset_rgb", 32'(rgb_out), 32'd0);
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    #1 rst_n = 1'b1;

    // Latency after release: two clocks.
    drive(11'd5, 11'd7, 1'b0, 1'b0, 12'h111);
    tick();
    chk("lat1_hcount", 32'(hcount_out), 32'd0);
    drive(11'd6, 11'd7, 1'b0, 1'b0, 12'h222);
    tick();
    chk("lat2_hcount", 32'(hcount_out), 32'd5);
    chk("lat2_vcount", 32'(vcount_out), 32'd7);
    chk("lat2_rgb", 32'(rgb_out), 32'h111);

    // Placement at (100,50); position and vblank rise arrive together (rise 1, frame 0).
    xpos = 11'd100; ypos = 11'd50; visible = 1'b1;
    vrise();
    drive(11'd100, 11'd50, 1'b0, 1'b0, 12'h123);
    chk("addr_top_left", 32'(rom_addr), 32'h000);
    tick();
    drive(11'd163, 11'd81, 1'b0, 1'b0, 12'h456);
    chk("addr_bot_right", 32'(rom_addr), 32'h7FF);
    tick();
    chk("rgb_top_left", 32'(rgb_out), 32'hFFF);
    chk("hcount_top_left", 32'(hcount_out), 32'd100);
    drive(11'd164, 11'd81, 1'b0, 1'b0, 12'h789);
    chk("addr_right_out", 32'(rom_addr), 32'h000);
    tick();
    chk("rgb_bot_right", 32'(rgb_out), 32'h800);
    drive(11'd110, 11'd50, 1'b0, 1'b1, 12'h555);
    chk("addr_in_hblnk", 32'(rom_addr), 32'h00A);
    tick();
    chk("rgb_right_out", 32'(rgb_out), 32'h789);
    drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h000);
    tick();
    chk("rgb_hblnk_black", 32'(rgb_out), 32'h000);

    // Tear-free: xpos changes mid-frame, box stays at 100 until the next vblank.
    xpos = 11'd200;
    drive(11'd100, 11'd60, 1'b0, 1'b0, 12'h000);
    chk("tear_old_pos", 32'(rom_addr), 32'h280);
    tick();
    drive(11'd200, 11'd60, 1'b0, 1'b0, 12'h000);
    chk("tear_new_not_yet", 32'(rom_addr), 32'h000);
    tick();
    vrise();  // rise 2: frame toggles to 1
    drive(11'd200, 11'd60, 1'b0, 1'b0, 12'h000);
    chk("next_frame_new_pos", 32'(rom_addr), 32'hA80);
    drive(11'd100, 11'd60, 1'b0, 1'b0, 12'h000);
    chk("next_frame_old_gone", 32'(rom_addr), 32'h000);

    // Animation with period 2: frame after rises 1..5 is 0,1,1,0,0.
    vrise();  // rise 3
    drive(11'd200, 11'd50, 1'b0, 1'b0, 12'h000);
    chk("anim_rise3", 32'(rom_addr), 32'h800);
    vrise();  // rise 4
    drive(11'd200, 11'd50, 1'b0, 1'b0, 12'h000);
    chk("anim_rise4", 32'(rom_addr), 32'h000);
    vrise();  // rise 5
    drive(11'd200, 11'd50, 1'b0, 1'b0, 12'h000);
    chk("anim_rise5", 32'(rom_addr), 32'h000);

    // Right edge: box at 2040 must not wrap into column 0 (rise 6, frame 1).
    xpos = 11'd2040;
    vrise();
    drive(11'd0, 11'd50, 1'b0, 1'b0, 12'h0AA);
    chk("edge_col0_addr", 32'(rom_addr), 32'h000);
    tick();
    drive(11'd2040, 11'd50, 1'b0, 1'b0, 12'h0BB);
    chk("edge_2040_addr", 32'(rom_addr), 32'h800);
    tick();
    chk("edge_col0_rgb", 32'(rgb_out), 32'h0AA);
    drive(11'd2047, 11'd50, 1'b0, 1'b0, 12'h0CC);
    chk("edge_2047_addr", 32'(rom_addr), 32'h807);
    tick();
    chk("edge_2040_rgb", 32'(rgb_out), 32'h7FF);

    // Key-coloured ROM pixel (rise 7, frame 1).
    xpos = 11'd100;
    vrise();
    rom_zero = 1'b1;
    drive(11'd120, 11'd60, 1'b0, 1'b0, 12'hABC);
    chk("transp_addr", 32'(rom_addr), 32'hA94);
    tick();
    drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h000);
    tick();
`ifdef INVADER_TRANSPARENT_EN
    chk("transp_rgb", 32'(rgb_out), 32'hABC);
`else
    chk("transp_rgb", 32'(rgb_out), 32'h000);
`endif
    rom_zero = 1'b0;

    // Invisible sprite: background passes through (rise 8).
    visible = 1'b0;
    vrise();
    drive(11'd120, 11'd60, 1'b0, 1'b0, 12'hDEF);
    chk("invis_addr", 32'(rom_addr), 32'h000);
    tick();
    drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h000);
    tick();
    chk("invis_rgb", 32'(rgb_out), 32'hDEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
